// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one imem request at a time and
// presents a registered {pc, inst} slot. Optional macro: FETCH_CTRL_ALIGN_CHECK_EN.
`timescale 1ns/1ps
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        addr_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DROP = 3'd3,
    S_HOLD = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] req_pc, req_pc_n;
  logic        if_valid_n;
  logic [31:0] if_pc_n, if_inst_n;
  logic        pend, pend_n;
  logic [31:0] redir_target;
  logic        misaligned;
  logic        inflight;

`ifdef FETCH_CTRL_ALIGN_CHECK_EN
  assign redir_target = redirect_pc;
  assign misaligned   = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign addr_err     = (state == S_ERR);
`else
  logic unused_redir_lsb;
  assign unused_redir_lsb = ^redirect_pc[1:0];
  assign redir_target     = {redirect_pc[31:2], 2'b00};
  assign misaligned       = 1'b0;
  assign addr_err         = 1'b0;
`endif

  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;

  // A request is still owed a response after this edge unless its rvalid arrives now.
  always_comb begin
    inflight = 1'b0;
    case (state)
      S_REQ:   inflight = imem_ready;
      S_WAIT:  inflight = !imem_rvalid;
      S_DROP:  inflight = !imem_rvalid;
      S_ERR:   inflight = pend && !imem_rvalid;
      default: inflight = 1'b0;
    endcase
  end

  // Next-state and next-register logic; redirect overrides every other event.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_pc_n   = req_pc;
    if_valid_n = if_valid;
    if_pc_n    = if_pc;
    if_inst_n  = if_inst;
    pend_n     = pend;
    if (redirect_valid) begin
      pc_n       = redir_target;
      if_valid_n = 1'b0;
      if (misaligned) begin
        state_n = S_ERR;
        pend_n  = inflight;
      end else begin
        // A stale response still owed must be absorbed before the next request.
        state_n = inflight ? S_DROP : S_REQ;
        pend_n  = 1'b0;
      end
    end else begin
      case (state)
        S_IDLE: state_n = S_REQ;
        S_REQ: begin
          if (imem_ready) begin
            req_pc_n = pc;
            pc_n     = pc + 32'd4;
            state_n  = S_WAIT;
          end else begin
            state_n = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if_inst_n  = imem_rdata;
            if_pc_n    = req_pc;
            if_valid_n = 1'b1;
            state_n    = S_HOLD;
          end else begin
            state_n = S_WAIT;
          end
        end
        S_DROP: begin
          if (imem_rvalid) begin
            state_n = S_REQ;
          end else begin
            state_n = S_DROP;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            if_valid_n = 1'b0;
            state_n    = S_REQ;
          end else begin
            state_n = S_HOLD;
          end
        end
        S_ERR: begin
          if (imem_rvalid) begin
            pend_n = 1'b0;
          end else begin
            pend_n = pend;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      req_pc   <= 32'd0;
      if_valid <= 1'b0;
      if_pc    <= 32'd0;
      if_inst  <= 32'd0;
      pend     <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      req_pc   <= req_pc_n;
      if_valid <= if_valid_n;
      if_pc    <= if_pc_n;
      if_inst  <= if_inst_n;
      pend     <= pend_n;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl with a small latency-programmable memory model.
`timescale 1ns/1ps
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid, addr_err;
  logic [31:0] if_pc, if_inst;

  int          tests = 0;
  int          fails = 0;
  int          mem_lat = 1;
  int          cnt = 0;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_data = 32'd0;
  logic [31:0] paddr = 32'd0;
  logic [31:0] acc_q[$];
  bit          seen_bad = 1'b0;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // Memory model: always ready, answers mem_lat cycles after acceptance.
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = ovr_en ? ovr_data : paddr;
      end
    end
    imem_ready = 1'b1;
    if (imem_req === 1'b1) begin
      paddr = imem_addr;
      cnt   = mem_lat;
      acc_q.push_back(imem_addr);
    end
    if (if_valid === 1'b1 && if_inst === 32'hDEAD_BEEF) seen_bad = 1'b1;
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    acc_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    repeat (3) @(negedge clk);
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    tests++; if ({if_valid, if_pc, if_inst, addr_err} !== 66'd0) begin fails++; $display("FAIL reset_slot got v=%b pc=%h inst=%h err=%b", if_valid, if_pc, if_inst, addr_err); end
    rst = 1'b0; cnt = 0; acc_q.delete();
    @(negedge clk);
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 3; k++) begin
      int n = 0;
      do begin @(negedge clk); n++; end while (if_valid !== 1'b1 && n < 12);
      tests++; if (n >= 12) begin fails++; $display("FAIL stream_timeout slot=%0d", k); end
      tests++; if (if_pc !== 32'(4*k) || if_inst !== 32'(4*k)) begin fails++; $display("FAIL stream_slot%0d got pc=%h inst=%h exp=%h", k, if_pc, if_inst, 4*k); end
      if (k > 0) begin
        tests++; if (n != 3) begin fails++; $display("FAIL stream_spacing%0d got=%0d exp=3", k, n); end
      end
    end
    tests++; if (acc_q.size() < 3 || acc_q[0] !== 32'h0 || acc_q[1] !== 32'h4 || acc_q[2] !== 32'h8) begin fails++; $display("FAIL stream_reqs got size=%0d", acc_q.size()); end
  endtask

  task automatic test_stall();
    int n = 0;
    do_reset();
    do begin @(negedge clk); n++; end while (!(if_valid === 1'b1 && if_pc === 32'h4) && n < 20);
    tests++; if (n >= 20) begin fails++; $display("FAIL stall_timeout waiting for pc 4"); end
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_inst !== 32'h4 || imem_req !== 1'b0) begin fails++; $display("FAIL stall_hold%0d got v=%b pc=%h inst=%h req=%b exp v=1 pc=4 inst=4 req=0", i, if_valid, if_pc, if_inst, imem_req); end
    end
    tests++; if (acc_q.size() != 2) begin fails++; $display("FAIL stall_noreq got accepts=%0d exp=2", acc_q.size()); end
    stall = 1'b0;
    @(negedge clk);
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || if_valid !== 1'b0) begin fails++; $display("FAIL stall_release got req=%b addr=%h v=%b exp req=1 addr=8 v=0", imem_req, imem_addr, if_valid); end
  endtask

  task automatic test_redirect_wait();
    int n = 0;
    mem_lat = 3; ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF; seen_bad = 1'b0;
    do_reset();
    @(negedge clk);                  // REQ to 0x0 accepted
    @(negedge clk);                  // WAIT
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0; mem_lat = 1;
    tests++; if (imem_req !== 1'b0 || imem_addr !== 32'h100 || if_valid !== 1'b0) begin fails++; $display("FAIL rw_drop got req=%b addr=%h v=%b exp req=0 addr=100 v=0", imem_req, imem_addr, if_valid); end
    @(negedge clk);                  // stale rvalid arrives
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rw_wait_stale got req=%b exp=0", imem_req); end
    @(negedge clk);
    ovr_en = 1'b0;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin fails++; $display("FAIL rw_newreq got req=%b addr=%h exp req=1 addr=100", imem_req, imem_addr); end
    do begin @(negedge clk); n++; end while (if_valid !== 1'b1 && n < 10);
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_inst !== 32'h100) begin fails++; $display("FAIL rw_slot got v=%b pc=%h inst=%h exp v=1 pc=100 inst=100", if_valid, if_pc, if_inst); end
    tests++; if (seen_bad) begin fails++; $display("FAIL rw_stale_presented got=1 exp=0"); end
  endtask

  task automatic test_redirect_ready();
    int n = 0;
    mem_lat = 1;
    do_reset();
    @(negedge clk);                  // REQ with ready
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    tests++; if (imem_req !== 1'b0 || imem_addr !== 32'h200) begin fails++; $display("FAIL rr_drop got req=%b addr=%h exp req=0 addr=200", imem_req, imem_addr); end
    @(negedge clk);
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin fails++; $display("FAIL rr_newreq got req=%b addr=%h exp req=1 addr=200", imem_req, imem_addr); end
    do begin @(negedge clk); n++; end while (if_valid !== 1'b1 && n < 10);
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_inst !== 32'h200) begin fails++; $display("FAIL rr_slot got v=%b pc=%h inst=%h exp v=1 pc=200 inst=200", if_valid, if_pc, if_inst); end
  endtask

  task automatic test_reset_in_wait();
    mem_lat = 1;
    do_reset();
    @(negedge clk);                  // REQ accepted
    @(negedge clk);                  // WAIT, rvalid this cycle
    rst = 1'b1;
    @(negedge clk);
    tests++; if ({imem_req, if_valid, if_pc, if_inst, addr_err} !== 67'd0 || imem_addr !== 32'h0) begin fails++; $display("FAIL rstw_outputs got req=%b addr=%h v=%b pc=%h inst=%h err=%b exp all 0", imem_req, imem_addr, if_valid, if_pc, if_inst, addr_err); end
    rst = 1'b0;
    @(negedge clk);
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL rstw_firstreq got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
  endtask

  task automatic test_align();
    int n = 0;
    mem_lat = 1;
    do_reset();
    do begin @(negedge clk); n++; end while (if_valid !== 1'b1 && n < 10);
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
`ifdef FETCH_CTRL_ALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      tests++; if (addr_err !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0) begin fails++; $display("FAIL align_err%0d got err=%b req=%b v=%b exp err=1 req=0 v=0", i, addr_err, imem_req, if_valid); end
      if (i < 3) @(negedge clk);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h104;
    @(negedge clk);
    redirect_valid = 1'b0;
    tests++; if (addr_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h104) begin fails++; $display("FAIL align_recover got err=%b req=%b addr=%h exp err=0 req=1 addr=104", addr_err, imem_req, imem_addr); end
`else
    tests++; if (addr_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin fails++; $display("FAIL align_mask got err=%b req=%b addr=%h exp err=0 req=1 addr=100", addr_err, imem_req, imem_addr); end
`endif
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_ready();
    test_reset_in_wait();
    test_align();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer between the program counter and the instruction memory port. Owns the PC, issues one instruction-memory request at a time with a req/ready + rvalid handshake, and presents a registered `{pc, instruction}` slot to the IF/ID boundary. Honours decode stalls and branch/jump redirects, and discards in-flight responses that a redirect has made stale.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC of the first fetch after reset; must be word-aligned.
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  downstream not accepting; the slot is consumed when `if_valid && !stall`.
- `redirect_valid`  in  1  one-cycle branch/jump redirect request.
- `redirect_pc`  in  32  redirect target.
- `imem_req`  out  1  request to instruction memory.
- `imem_addr`  out  32  byte address of the request.
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  response data valid; exactly one per accepted request.
- `imem_rdata`  in  32  instruction word.
- `if_valid`  out  1  output slot holds an instruction.
- `if_pc`  out  32  PC of the instruction in the slot.
- `if_inst`  out  32  instruction in the slot.
- `addr_err`  out  1  misaligned redirect flag (see Configuration).

## Operation
- States: IDLE, REQ, WAIT, DROP, HOLD (plus ERR with the macro). Registers: `pc` (next fetch address), `req_pc` (address of the outstanding request).
- Reset: state IDLE, `pc`=RESET_PC, `req_pc`=0, `imem_req`=0, `imem_addr`=RESET_PC, `if_valid`=0, `if_pc`=0, `if_inst`=0, `addr_err`=0.
- `imem_req`=1 only in REQ. `imem_addr`=`pc` at all times.
- Redirect has priority over all other events in every state. In every state it sets `pc`←`redirect_pc` and `if_valid`←0 on the next edge.
- IDLE: moves to REQ unconditionally.
- REQ:
  - `imem_ready`=1 and no redirect: `req_pc`←`pc`, `pc`←`pc`+4 (mod 2^32), go to WAIT.
  - `imem_ready`=1 with redirect: the accepted request is stale; go to DROP.
  - Redirect without `imem_ready`: stay in REQ with the new address. Memory samples `imem_addr` only on `req && ready`, so the address may change before acceptance.
- WAIT:
  - `imem_rvalid`=1 and no redirect: `if_inst`←`imem_rdata`, `if_pc`←`req_pc`, `if_valid`←1, go to HOLD.
  - `imem_rvalid`=1 with redirect: discard the data, go to REQ.
  - Redirect without `imem_rvalid`: go to DROP.
- DROP: on `imem_rvalid`, discard the data and go to REQ. Further redirects only update `pc`.
- HOLD:
  - `stall`=1: hold the slot unchanged.
  - `stall`=0: `if_valid`←0, go to REQ.
  - Redirect: `if_valid`←0, go to REQ.
- Never more than one outstanding request. `imem_rvalid` outside WAIT/DROP is ignored.

## Timing
- `rst` is sampled at the edge. Reset dominates every event, including a response arriving in the same cycle. An outstanding request cut off by reset has its response ignored, because the post-reset state is IDLE.
- Earliest `imem_req`: first cycle after the first edge with `rst`=0.
- Zero-wait memory (ready in the REQ cycle, rvalid the next cycle): REQ→WAIT→HOLD. `if_valid` rises 2 edges after REQ entry. Peak throughput is one instruction per 3 cycles.
- Redirect to new request: `imem_req` with `imem_addr`=target is visible in the cycle after the redirect. The exception is DROP, where it waits for the stale rvalid.
- All outputs are registered or decoded from state; there is no combinational input→output path.

## Configuration
- `FETCH_CTRL_ALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0 enters ERR.
  - In ERR: `imem_req`=0, `if_valid`=0, `addr_err`=1 (sticky).
  - A pending response is still absorbed and discarded in ERR.
  - Only an aligned redirect (→REQ) or `rst` leaves ERR.
- `FETCH_CTRL_ALIGN_CHECK_EN` undefined: `addr_err` tied 0; `redirect_pc[1:0]` is masked to 00.

## Test plan
- Reset then zero-wait memory returning `{addr}` as data, `stall`=0 → requests at 0x0, 0x4, 0x8. `if_pc`/`if_inst` = 0x0, 0x4, 0x8, one per 3 cycles.
- `stall`=1 for 5 cycles while HOLD has pc 0x4 → slot stable at 0x4, `imem_req`=0 throughout; the next request to 0x8 follows the cycle after release.
- Redirect to 0x100 in WAIT, rvalid 2 cycles later with 0xDEAD_BEEF → 0xDEAD_BEEF is never presented; the next request is 0x100 and `if_pc`=0x100.
- Redirect to 0x200 in the same cycle as `imem_ready` → DROP, the stale response is discarded, and the next request is 0x200.
- `rst` asserted in WAIT with rvalid in the same cycle → all outputs at reset values, the first request after release goes to RESET_PC.
- With the macro: redirect to 0x102 → `addr_err`=1 and no requests; a later redirect to 0x104 → `addr_err`=0 and a request to 0x104. Without the macro, redirect 0x102 → request to 0x100.
